// File: rtl/fetch_pc_unit.sv
// Instruction fetch: owns the PC, issues single-outstanding word requests and drives IF/ID through a one-entry skid.
// Latency: request with gnt in cycle N, rvalid N+1, IF_Valid_o at N+2; Stall_i parks one response in the skid and blocks new requests.
// Optional FETCH_PERF_CNT_EN adds saturating fetch/kill/stall counters.
module fetch_pc_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_i,
   input  logic        PC_Branch_Select,
   input  logic [31:0] Branch_Target,
   input  logic        Jump_Taken_i,
   input  logic [31:0] Jump_Target_i,
   input  logic        Stall_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] IF_PC_o,
   output logic [31:0] IF_Instr_o,
   output logic        IF_Valid_o,
   output logic        Flush_o
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] Perf_Fetch_o,
   output logic [31:0] Perf_Kill_o,
   output logic [31:0] Perf_Stall_o
`endif
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DRAIN} state_t;

   state_t      state_q;
   logic [31:0] pc_q;
   logic [31:0] req_pc_q;
   logic        skid_vld_q;
   logic [31:0] skid_pc_q;
   logic [31:0] skid_instr_q;
   logic [31:0] if_pc_q;
   logic [31:0] if_instr_q;
   logic        if_vld_q;

   logic        redirect;
   logic [31:0] redirect_tgt;
   logic        grant;
   logic        rsp_pending;
   logic        in_flight_next;
   logic        rsp_take;
   logic        kill;

   always_comb begin
      redirect     = start_i & (PC_Branch_Select | Jump_Taken_i);
      redirect_tgt = (PC_Branch_Select ? Branch_Target : Jump_Target_i) & 32'hFFFF_FFFC;
      // A full skid means IF/ID and skid both hold work; stop fetching until it drains.
      imem_req_o   = (state_q == REQ) & ~skid_vld_q;
      imem_addr_o  = imem_req_o ? pc_q : 32'h0000_0000;
      grant        = imem_req_o & imem_gnt_i;
      rsp_pending  = (state_q == WAIT_RSP) | (state_q == DRAIN);
      in_flight_next = grant | (rsp_pending & ~imem_rvalid_i);
      kill         = ~start_i | redirect;
      rsp_take     = (state_q == WAIT_RSP) & imem_rvalid_i & ~kill;
      Flush_o      = redirect;
   end

   assign IF_PC_o    = if_pc_q;
   assign IF_Instr_o = if_instr_q;
   assign IF_Valid_o = if_vld_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         pc_q         <= RESET_PC;
         req_pc_q     <= RESET_PC;
         skid_vld_q   <= 1'b0;
         skid_pc_q    <= RESET_PC;
         skid_instr_q <= NOP_INSTR;
         if_pc_q      <= RESET_PC;
         if_instr_q   <= NOP_INSTR;
         if_vld_q     <= 1'b0;
      end else if (kill) begin
         // Anything still in flight must be swallowed by DRAIN before the next request.
         pc_q       <= start_i ? redirect_tgt : RESET_PC;
         skid_vld_q <= 1'b0;
         if_vld_q   <= 1'b0;
         if_instr_q <= NOP_INSTR;
         if (in_flight_next)
            state_q <= DRAIN;
         else if (start_i)
            state_q <= REQ;
         else
            state_q <= IDLE;
      end else begin
         if (grant) begin
            req_pc_q <= pc_q;
            pc_q     <= pc_q + 32'd4;
         end

         if (!Stall_i) begin
            if (skid_vld_q) begin
               if_pc_q    <= skid_pc_q;
               if_instr_q <= skid_instr_q;
               if_vld_q   <= 1'b1;
               skid_vld_q <= 1'b0;
            end else if (rsp_take) begin
               if_pc_q    <= req_pc_q;
               if_instr_q <= imem_rdata_i;
               if_vld_q   <= 1'b1;
            end else begin
               if_instr_q <= NOP_INSTR;
               if_vld_q   <= 1'b0;
            end
         end else if (rsp_take) begin
            skid_pc_q    <= req_pc_q;
            skid_instr_q <= imem_rdata_i;
            skid_vld_q   <= 1'b1;
         end

         case (state_q)
            IDLE:     state_q <= REQ;
            REQ:      if (grant) state_q <= WAIT_RSP;
            WAIT_RSP: if (imem_rvalid_i) state_q <= REQ;
            DRAIN:    if (imem_rvalid_i) state_q <= REQ;
            default:  state_q <= IDLE;
         endcase
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic fetch_inc;
   logic kill_inc;
   logic stall_inc;

   always_comb begin
      fetch_inc = ~kill & ~Stall_i & (skid_vld_q | rsp_take);
      kill_inc  = imem_rvalid_i & rsp_pending & ~rsp_take;
      stall_inc = Stall_i & if_vld_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         Perf_Fetch_o <= 32'h0000_0000;
         Perf_Kill_o  <= 32'h0000_0000;
         Perf_Stall_o <= 32'h0000_0000;
      end else begin
         if (fetch_inc && (Perf_Fetch_o != 32'hFFFF_FFFF)) Perf_Fetch_o <= Perf_Fetch_o + 32'd1;
         if (kill_inc  && (Perf_Kill_o  != 32'hFFFF_FFFF)) Perf_Kill_o  <= Perf_Kill_o + 32'd1;
         if (stall_inc && (Perf_Stall_o != 32'hFFFF_FFFF)) Perf_Stall_o <= Perf_Stall_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed scenarios plus randomized traffic against a queue-based fetch model.
module tb_fetch_pc_unit;

   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_i;
   logic        PC_Branch_Select;
   logic [31:0] Branch_Target;
   logic        Jump_Taken_i;
   logic [31:0] Jump_Target_i;
   logic        Stall_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic [31:0] IF_PC_o;
   logic [31:0] IF_Instr_o;
   logic        IF_Valid_o;
   logic        Flush_o;

   always #5 clk = ~clk;

   fetch_pc_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .start_i          (start_i),
      .PC_Branch_Select (PC_Branch_Select),
      .Branch_Target    (Branch_Target),
      .Jump_Taken_i     (Jump_Taken_i),
      .Jump_Target_i    (Jump_Target_i),
      .Stall_i          (Stall_i),
      .imem_req_o       (imem_req_o),
      .imem_addr_o      (imem_addr_o),
      .imem_gnt_i       (imem_gnt_i),
      .imem_rvalid_i    (imem_rvalid_i),
      .imem_rdata_i     (imem_rdata_i),
      .IF_PC_o          (IF_PC_o),
      .IF_Instr_o       (IF_Instr_o),
      .IF_Valid_o       (IF_Valid_o),
      .Flush_o          (Flush_o)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A3C, ~a[31:16]};
   endfunction

   // Reference model: in-flight requests, accepted-but-undelivered responses, IF/ID contents.
   typedef struct { logic [31:0] addr; bit killed; } pend_t;
   typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;

   pend_t       pend[$];
   ent_t        acc[$];
   logic        m_vld;
   logic [31:0] m_pc;
   logic [31:0] m_ins;
   logic [31:0] m_fetch;
   int          n_deliv = 0;
   int          cyc = 0;
   int          first_vld_cyc = -1;
   bit          last_grant;
   bit          last_flush;
   bit          last_req;
   logic [31:0] last_grant_addr;
   logic [31:0] grant_log[$];
   int          resp_cnt = 0;
   logic [31:0] resp_addr;
   int          lat_lo = 1;
   int          lat_hi = 1;

   task automatic step();
      bit          g, rv, kl, stl, fl, st;
      logic [31:0] tgt;
      pend_t       p;
      ent_t        e;
      @(negedge clk);
      st  = start_i;
      fl  = st & (PC_Branch_Select | Jump_Taken_i);
      tgt = (PC_Branch_Select ? Branch_Target : Jump_Target_i) & 32'hFFFF_FFFC;
      chk("flush", Flush_o, fl);
      chk("req_while_outstanding", imem_req_o && (pend.size() != 0), 1'b0);
      chk("req_while_skid_full", imem_req_o && (acc.size() != 0), 1'b0);
      g          = imem_req_o & imem_gnt_i;
      last_grant = g;
      last_flush = Flush_o;
      last_req   = imem_req_o;
      if (g) begin
         chk("fetch_addr", imem_addr_o, m_fetch);
         last_grant_addr = imem_addr_o;
         grant_log.push_back(imem_addr_o);
      end
      rv  = imem_rvalid_i;
      stl = Stall_i;
      kl  = !st || fl;
      @(posedge clk);
      #1;
      cyc++;
      if (rv && pend.size() != 0) begin
         p = pend.pop_front();
         if (!p.killed && !kl) begin
            e.pc  = p.addr;
            e.ins = mem_word(p.addr);
            acc.push_back(e);
         end
      end
      if (g) begin
         p.addr   = last_grant_addr;
         p.killed = kl;
         pend.push_back(p);
      end
      if (kl) begin
         foreach (pend[i]) pend[i].killed = 1'b1;
         acc.delete();
         m_vld = 1'b0;
         m_ins = NOP_INSTR;
      end else if (!stl) begin
         if (acc.size() != 0) begin
            e     = acc.pop_front();
            m_vld = 1'b1;
            m_pc  = e.pc;
            m_ins = e.ins;
            n_deliv++;
         end else begin
            m_vld = 1'b0;
            m_ins = NOP_INSTR;
         end
      end
      if (!st)      m_fetch = RESET_PC;
      else if (fl)  m_fetch = tgt;
      else if (g)   m_fetch = m_fetch + 32'd4;
      chk("if_valid", IF_Valid_o, m_vld);
      if (m_vld) begin
         chk("if_pc", IF_PC_o, m_pc);
         chk("if_instr", IF_Instr_o, m_ins);
      end else begin
         chk("if_instr_nop", IF_Instr_o, NOP_INSTR);
      end
      if (IF_Valid_o && first_vld_cyc < 0) first_vld_cyc = cyc;
      // Memory responder: one response, lat_lo..lat_hi cycles after the grant.
      if (g) begin
         resp_cnt  = $urandom_range(lat_hi, lat_lo);
         resp_addr = last_grant_addr;
      end
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = $urandom;
      if (resp_cnt > 0) begin
         resp_cnt--;
         if (resp_cnt == 0) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_word(resp_addr);
         end
      end
   endtask

   task automatic wait_grant(input int budget, output logic [31:0] a);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (!last_grant && n < budget);
      chk("grant_timeout", last_grant, 1'b1);
      a = last_grant_addr;
   endtask

   task automatic random_inputs();
      start_i          = ($urandom_range(99) >= 2);
      PC_Branch_Select = ($urandom_range(99) < 4);
      Jump_Taken_i     = ($urandom_range(99) < 4);
      Branch_Target    = ($urandom_range(9) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_0FFF);
      Jump_Target_i    = ($urandom_range(9) == 0) ? 32'hFFFF_FFF4 : ($urandom & 32'h0000_0FFF);
      Stall_i          = ($urandom_range(99) < 25);
      imem_gnt_i       = ($urandom_range(99) < 70);
   endtask

   initial begin
      logic [31:0] a;
      logic [31:0] pc_before;
      logic        vld_before;
      int          nreq;

      rst_n = 1'b0;
      start_i = 1'b0;
      PC_Branch_Select = 1'b0;
      Branch_Target = '0;
      Jump_Taken_i = 1'b0;
      Jump_Target_i = '0;
      Stall_i = 1'b0;
      imem_gnt_i = 1'b0;
      imem_rvalid_i = 1'b0;
      imem_rdata_i = '0;
      m_vld = 1'b0;
      m_pc = RESET_PC;
      m_ins = NOP_INSTR;
      m_fetch = RESET_PC;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_if_pc", IF_PC_o, RESET_PC);
      chk("rst_if_instr", IF_Instr_o, NOP_INSTR);
      chk("rst_if_valid", IF_Valid_o, 1'b0);
      chk("rst_req", imem_req_o, 1'b0);
      chk("rst_addr", imem_addr_o, 32'h0);
      chk("rst_flush", Flush_o, 1'b0);
      rst_n = 1'b1;

      // Basic in-order fetch, gnt always, rvalid one cycle after gnt.
      start_i = 1'b1;
      imem_gnt_i = 1'b1;
      cyc = 0;
      repeat (6) step();
      chk("basic_grants", grant_log.size(), 3);
      for (int i = 0; i < 3 && i < grant_log.size(); i++)
         chk("basic_addr", grant_log[i], 32'(i * 4));
      chk("first_valid_cycle", first_vld_cyc, 3);

      // Branch during WAIT_RSP.
      lat_lo = 3; lat_hi = 3;
      wait_grant(20, a);
      PC_Branch_Select = 1'b1;
      Branch_Target = 32'h0000_0102;
      step();
      PC_Branch_Select = 1'b0;
      chk("br_flush", last_flush, 1'b1);
      chk("br_bubble", IF_Valid_o, 1'b0);
      wait_grant(20, a);
      chk("br_target", a, 32'h0000_0100);

      // Branch beats jump in the same cycle.
      wait_grant(20, a);
      PC_Branch_Select = 1'b1; Branch_Target = 32'h0000_0200;
      Jump_Taken_i = 1'b1;     Jump_Target_i = 32'h0000_0300;
      step();
      PC_Branch_Select = 1'b0; Jump_Taken_i = 1'b0;
      wait_grant(20, a);
      chk("branch_priority", a, 32'h0000_0200);

      // Stall while the response arrives: skid holds it, fetch pauses.
      lat_lo = 1; lat_hi = 1;
      wait_grant(20, a);
      pc_before = IF_PC_o;
      vld_before = IF_Valid_o;
      Stall_i = 1'b1;
      nreq = 0;
      repeat (3) begin
         step();
         if (last_req) nreq++;
      end
      chk("stall_no_req", nreq, 0);
      chk("stall_hold_pc", IF_PC_o, pc_before);
      chk("stall_hold_vld", IF_Valid_o, vld_before);
      Stall_i = 1'b0;
      step();
      chk("skid_release_pc", IF_PC_o, a);
      chk("skid_release_vld", IF_Valid_o, 1'b1);
      begin
         logic [31:0] b;
         wait_grant(20, b);
         chk("resume_addr", b, a + 32'd4);
      end

      // start_i drop with a request outstanding.
      lat_lo = 3; lat_hi = 3;
      wait_grant(20, a);
      start_i = 1'b0;
      nreq = 0;
      repeat (6) begin
         step();
         if (last_req) nreq++;
      end
      chk("stop_no_req", nreq, 0);
      chk("stop_invalid", IF_Valid_o, 1'b0);
      start_i = 1'b1;
      wait_grant(20, a);
      chk("restart_addr", a, RESET_PC);

      // PC wrap at the top of the address space.
      lat_lo = 1; lat_hi = 1;
      wait_grant(20, a);
      Jump_Taken_i = 1'b1;
      Jump_Target_i = 32'hFFFF_FFFE;
      step();
      Jump_Taken_i = 1'b0;
      wait_grant(20, a);
      chk("wrap_top", a, 32'hFFFF_FFFC);
      wait_grant(20, a);
      chk("wrap_zero", a, 32'h0000_0000);

      // Randomized traffic.
      lat_lo = 1; lat_hi = 4;
      for (int i = 0; i < 3000; i++) begin
         random_inputs();
         step();
      end
      chk("progress", (n_deliv > 100), 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
Instruction-fetch stage: owns the program counter, issues word requests to instruction memory and drives the IF/ID pipeline register. Consumes the taken/not-taken decision from the EX-stage branch comparator (PC_Branch_Select) plus its target, and the ID-stage jump redirect. Provides IF/ID stall support through a one-entry skid buffer. Flushes younger work on redirect.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset or after start_i falls
NOP_INSTR, 32'h0000_0013, instruction presented on IF_Instr_o when IF_Valid_o=0

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
start_i  in  1  core run enable; low forces IDLE
PC_Branch_Select  in  1  EX branch taken
Branch_Target  in  32  EX branch target address
Jump_Taken_i  in  1  ID jump (JAL/JALR) taken
Jump_Target_i  in  32  ID jump target address
Stall_i  in  1  hazard unit: hold IF/ID register
imem_req_o  out  1  fetch request
imem_addr_o  out  32  fetch word address
imem_gnt_i  in  1  request accepted this cycle
imem_rvalid_i  in  1  read data valid (any latency >=1 after gnt)
imem_rdata_i  in  32  instruction word
IF_PC_o  out  32  PC of IF/ID instruction
IF_Instr_o  out  32  IF/ID instruction
IF_Valid_o  out  1  IF/ID holds a real instruction
Flush_o  out  1  redirect this cycle (combinational)

Behaviour:
- Reset (rst_n=0, async): pc_q=RESET_PC, state IDLE, skid empty, IF_PC_o=RESET_PC, IF_Instr_o=NOP_INSTR, IF_Valid_o=0, imem_req_o=0, imem_addr_o=0.
- States IDLE, REQ, WAIT_RSP, DRAIN; at most one outstanding request.
- IDLE: imem_req_o=0; start_i=1 -> REQ next cycle.
- REQ: imem_req_o=1, imem_addr_o=pc_q; only entered/held with skid empty. On gnt: req_pc<=pc_q, pc_q<=pc_q+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), -> WAIT_RSP.
- WAIT_RSP: on rvalid, response (req_pc, rdata) goes to IF/ID if Stall_i=0, else into skid; -> REQ if skid will be empty, else stay in REQ-blocked wait until skid drains.
- IF/ID update when Stall_i=0: load skid if full (skid empties), else load same-cycle response, else bubble (IF_Valid_o=0, IF_Instr_o=NOP_INSTR). Stall_i=1: IF/ID and skid hold.
- Redirect = start_i & (PC_Branch_Select | Jump_Taken_i); PC_Branch_Select has priority (older instruction). Target low two bits forced to 0.
- On redirect: Flush_o=1 same cycle; next edge pc_q<=target, IF_Valid_o<=0 regardless of Stall_i, skid cleared. If a request is outstanding without rvalid this cycle (WAIT_RSP, or REQ with gnt) -> DRAIN; else -> REQ. rvalid coinciding with redirect is discarded.
- DRAIN: imem_req_o=0; next rvalid discarded, -> REQ (or IDLE if start_i=0).
- start_i=0 in any state: pc_q<=RESET_PC, IF_Valid_o<=0, skid cleared, Flush_o=0; outstanding request -> DRAIN then IDLE, else IDLE.
- Best-case latency: request cycle N with gnt, rvalid N+1, IF_Valid_o=1 at N+2; throughput one fetch per 2 cycles.

Optional Feature:
FETCH_PERF_CNT_EN: adds outputs Perf_Fetch_o[31:0] (instructions loaded into IF/ID with valid), Perf_Kill_o[31:0] (responses discarded), Perf_Stall_o[31:0] (cycles Stall_i=1 with IF_Valid_o=1); reset to 0, saturate at 32'hFFFF_FFFF. Without macro: ports and counters absent, behaviour otherwise identical.

Test Plan:
Reset release, start_i=1, gnt always, rvalid 1 cycle after gnt -> imem_addr_o 0,4,8; IF_PC_o 0,4,8 with matching rdata, IF_Valid_o=1 from cycle 3.
PC_Branch_Select=1, Branch_Target=32'h0000_0102 during WAIT_RSP -> Flush_o=1 that cycle, old response discarded, next imem_addr_o=32'h0000_0100, IF_Valid_o=0 one cycle.
PC_Branch_Select=1 target 0x200 and Jump_Taken_i=1 target 0x300 same cycle -> next fetch address 0x200.
Stall_i=1 for 3 cycles while response arrives -> skid holds it, no new imem_req_o, IF/ID unchanged; on release skid instruction appears, then fetching resumes in order.
start_i dropped with request outstanding, rvalid 3 cycles later -> data discarded, IDLE, restart fetches RESET_PC.
pc_q=32'hFFFF_FFFC fetched -> next imem_addr_o=32'h0000_0000.
